// File: rtl/prog_rom_loader.sv
// ---------------------------------------------------------------------------
// prog_rom_loader
//   Program memory for the RSSB core: a DEPTH x WIDTH array with a streaming
//   load port (boot/test loader side), a registered read port (datapath
//   side) and a hardware clear sequence that zeroes every word after reset.
//
// Ports
//   clk, rst     : single clock, synchronous active-high reset
//   load_start   : begin a load (accepted only in IDLE)
//   load_valid   : load_data valid this cycle
//   load_data    : word written at the current load pointer
//   load_last    : accepted word is the final one of the load
//   load_ready   : load word accepted this cycle (LOAD state only)
//   load_done    : one-cycle pulse on the first IDLE cycle after a load
//   load_count   : words written by the current / most recent load
//   rd_en        : read request (serviced only in IDLE)
//   rd_addr      : read address
//   rd_data      : registered read data (1-cycle latency)
//   rd_valid     : rd_data updated by the read of the previous cycle
//   mem_ready    : core may fetch (IDLE only)
// ---------------------------------------------------------------------------
module prog_rom_loader #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_last,
   output logic             load_ready,
   output logic             load_done,
   output logic [AW:0]      load_count,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             mem_ready
);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [AW-1:0]      r_clr_ptr;
   logic [AW-1:0]      r_ld_ptr;
   logic [AW:0]        r_load_count;
   logic [WIDTH-1:0]   r_rd_data;
   logic               r_rd_valid;
   logic               r_load_done;
   logic [WIDTH-1:0]   r_mem [DEPTH];

   logic               w_clr_we;
   logic               w_clr_end;
   logic               w_accept;
   logic               w_ld_end;
   logic               w_rd_fire;
   logic               w_rd_in_range;

   assign w_clr_we      = (r_state == S_CLEAR);
   assign w_clr_end     = w_clr_we && (r_clr_ptr == LAST_ADDR);
   assign w_accept      = (r_state == S_LOAD) && load_valid;
   // A load terminates on an explicit last word or on the top address,
   // whichever arrives first, so the pointer never wraps onto old data.
   assign w_ld_end      = w_accept && (load_last || (r_ld_ptr == LAST_ADDR));
   assign w_rd_fire     = (r_state == S_IDLE) && rd_en;
   // Only reachable out of range when DEPTH is not a power of two.
   assign w_rd_in_range = ({1'b0, rd_addr} < (AW + 1)'(DEPTH));

   // Status outputs are forced low while rst is asserted, whatever the
   // state register still holds during that cycle.
   assign load_ready = (r_state == S_LOAD) && !rst;
   assign mem_ready  = (r_state == S_IDLE) && !rst;
   assign load_done  = r_load_done;
   assign load_count = r_load_count;
   assign rd_data    = r_rd_data;
   assign rd_valid   = r_rd_valid;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_CLEAR: if (w_clr_end)  w_next_state = S_IDLE;
         S_IDLE:  if (load_start) w_next_state = S_LOAD;
         S_LOAD:  if (w_ld_end)   w_next_state = S_IDLE;
         default:                 w_next_state = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_CLEAR;
         r_clr_ptr    <= '0;
         r_ld_ptr     <= '0;
         r_load_count <= '0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
         r_load_done  <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_load_done <= w_ld_end;
         r_rd_valid  <= w_rd_fire;
         if (w_rd_fire)
            r_rd_data <= w_rd_in_range ? r_mem[rd_addr] : '0;
         if (w_clr_we)
            r_clr_ptr <= r_clr_ptr + 1'b1;
         if ((r_state == S_IDLE) && load_start) begin
            r_ld_ptr     <= '0;
            r_load_count <= '0;
         end else if (w_accept) begin
            r_ld_ptr     <= r_ld_ptr + 1'b1;
            r_load_count <= r_load_count + 1'b1;
         end
      end
   end

   // Storage has no reset of its own; the CLEAR sequence zeroes it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_clr_we)
            r_mem[r_clr_ptr] <= '0;
         else if (w_accept)
            r_mem[r_ld_ptr] <= load_data;
      end
   end

endmodule

// File: tb/tb_prog_rom_loader.sv
module tb_prog_rom_loader;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: DEPTH=16
   logic       rst, load_start, load_valid, load_last, rd_en;
   logic [7:0] load_data;
   logic [3:0] rd_addr;
   logic       load_ready, load_done, rd_valid, mem_ready;
   logic [4:0] load_count;
   logic [7:0] rd_data;

   // Instance B: DEPTH=12
   logic       b_rst, b_load_start, b_load_valid, b_load_last, b_rd_en;
   logic [7:0] b_load_data;
   logic [3:0] b_rd_addr;
   logic       b_load_ready, b_load_done, b_rd_valid, b_mem_ready;
   logic [4:0] b_load_count;
   logic [7:0] b_rd_data;

   int n_total = 0;
   int n_bad   = 0;
   int pulses;
   logic [7:0] words [32];
   logic [7:0] prog [14] = '{0,0,0,1,1,2,0,0,1,0,0,0,3,1};

   prog_rom_loader #(.WIDTH(8), .DEPTH(16)) u_dut_a (
      .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
      .load_done(load_done), .load_count(load_count), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .mem_ready(mem_ready));

   prog_rom_loader #(.WIDTH(8), .DEPTH(12)) u_dut_b (
      .clk(clk), .rst(b_rst), .load_start(b_load_start), .load_valid(b_load_valid),
      .load_data(b_load_data), .load_last(b_load_last), .load_ready(b_load_ready),
      .load_done(b_load_done), .load_count(b_load_count), .rd_en(b_rd_en),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .mem_ready(b_mem_ready));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_a(input logic [3:0] addr, input logic [7:0] exp, input string tag);
      rd_en   = 1'b1;
      rd_addr = addr;
      step();
      rd_en = 1'b0;
      chk({tag, "_vld"}, rd_valid, 1);
      chk(tag, rd_data, exp);
   endtask

   // Clear sequence on A: mem_ready low for exactly 16 cycles, no load_done.
   task automatic clear_a(input string tag);
      int lo = 0;
      for (int i = 0; i < 16; i++) begin
         if (!mem_ready) lo++;
         if (load_done) pulses++;
         step();
      end
      chk({tag, "_lo_cycles"}, lo, 16);
      chk({tag, "_ready"}, mem_ready, 1);
   endtask

   // Load n words from words[] on A; use_last marks the final one.
   task automatic load_a(input int n, input bit use_last);
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      chk("ld_ready_on", load_ready, 1);
      chk("ld_memrdy_off", mem_ready, 0);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = words[i];
         load_last  = use_last && (i == n - 1);
         step();
         if (load_done) pulses++;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic all_zero_a(input string tag);
      int nz = 0;
      for (int a = 0; a < 16; a++) begin
         rd_en   = 1'b1;
         rd_addr = 4'(a);
         step();
         if (!rd_valid || rd_data != 8'h00) nz++;
      end
      rd_en = 1'b0;
      chk(tag, nz, 0);
   endtask

   initial begin
      rst = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = 0;
      rd_en = 0; rd_addr = 0;
      b_rst = 1'b1; b_load_start = 0; b_load_valid = 0; b_load_last = 0;
      b_load_data = 0; b_rd_en = 0; b_rd_addr = 0;

      // Reset then clear
      step();
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_done", load_done, 0);
      chk("rst_count", load_count, 0);
      chk("rst_memrdy", mem_ready, 0);
      chk("rst_ldrdy", load_ready, 0);
      rst = 1'b0;
      pulses = 0;
      clear_a("clr1");
      for (int a = 0; a < 16; a++) rd_a(4'(a), 8'h00, "clr_rd");

      // Program load with load_last on the 14th word
      for (int i = 0; i < 14; i++) words[i] = prog[i];
      load_a(14, 1'b1);
      chk("prog_done", load_done, 1);
      chk("prog_memrdy", mem_ready, 1);
      chk("prog_count", load_count, 14);
      rd_a(4'd3, 8'd1, "prog_a3");
      chk("prog_done_once", pulses + int'(load_done), 1);
      rd_a(4'd5, 8'd2, "prog_a5");
      rd_a(4'd12, 8'd3, "prog_a12");
      rd_a(4'd13, 8'd1, "prog_a13");
      rd_a(4'd14, 8'd0, "prog_a14");
      chk("prog_count_hold", load_count, 14);

      // Full-depth wrap: 16 words, no load_last
      for (int i = 0; i < 16; i++) words[i] = 8'h10 + 8'(i);
      load_a(16, 1'b0);
      chk("wrap_done", pulses, 1);
      chk("wrap_ldrdy", load_ready, 0);
      chk("wrap_count", load_count, 16);
      load_valid = 1'b1; load_data = 8'hAA;
      step();
      step();
      load_valid = 1'b0;
      chk("wrap_count_hold", load_count, 16);
      rd_a(4'd0, 8'h10, "wrap_a0");
      rd_a(4'd15, 8'h1F, "wrap_a15");

      // Stalls and ignored inputs mid-load
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1; load_data = 8'h40 + 8'(i);
         step();
      end
      load_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd_en      = (i == 2);
         rd_addr    = 4'd0;
         load_start = (i == 2);
         step();
         chk("stall_rdvld", rd_valid, 0);
      end
      rd_en = 1'b0; load_start = 1'b0;
      chk("stall_ldrdy", load_ready, 1);
      chk("stall_count", load_count, 3);
      load_valid = 1'b1; load_data = 8'h43;
      step();
      load_data = 8'h44; load_last = 1'b1;
      step();
      load_valid = 1'b0; load_last = 1'b0;
      chk("stall_done", load_done, 1);
      chk("stall_count_end", load_count, 5);
      rd_a(4'd0, 8'h40, "stall_a0");
      rd_a(4'd2, 8'h42, "stall_a2");
      rd_a(4'd3, 8'h43, "stall_a3");
      rd_a(4'd4, 8'h44, "stall_a4");
      rd_a(4'd5, 8'h15, "stall_a5");

      // Reset mid-load after 3 of 8 words
      for (int i = 0; i < 8; i++) words[i] = 8'h50 + 8'(i);
      load_a(3, 1'b0);
      chk("mid_count3", load_count, 3);
      rst = 1'b1; load_valid = 1'b1; load_data = 8'h53;
      step();
      load_valid = 1'b0;
      chk("mid_done", load_done, 0);
      chk("mid_count", load_count, 0);
      chk("mid_memrdy", mem_ready, 0);
      rst = 1'b0;
      pulses = 0;
      clear_a("clr2");
      chk("mid_no_done", pulses, 0);
      all_zero_a("mid_all_zero");

      // Non-power-of-two depth (instance B, DEPTH=12)
      b_rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (b_mem_ready) pulses++;
         step();
      end
      chk("b_ready", b_mem_ready, 1);
      b_load_start = 1'b1;
      step();
      b_load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b_load_valid = 1'b1; b_load_data = 8'h07 + 8'(i); b_load_last = (i == 2);
         step();
      end
      b_load_valid = 1'b0; b_load_last = 1'b0;
      chk("b_done", b_load_done, 1);
      b_rd_en = 1'b1; b_rd_addr = 4'd2;
      step();
      chk("b_a2", b_rd_data, 8'h09);
      b_rd_addr = 4'd13;
      step();
      b_rd_en = 1'b0;
      chk("b_oor_vld", b_rd_valid, 1);
      chk("b_oor_data", b_rd_data, 8'h00);
      b_rd_en = 1'b1; b_rd_addr = 4'd2; b_load_start = 1'b1;
      step();
      b_rd_en = 1'b0; b_load_start = 1'b0;
      chk("b_both_vld", b_rd_valid, 1);
      chk("b_both_data", b_rd_data, 8'h09);
      chk("b_both_ldrdy", b_load_ready, 1);
      chk("b_both_memrdy", b_mem_ready, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
